multicycle_control_unit: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle RV32I decoder. It holds an explicit state machine that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It talks to a variable-latency memory through a req/ready handshake and resolves all six RV32I branch conditions. It sits between the instruction register (IR), register file, ALU and unified memory of the multi-cycle datapath.

---
 rtl/riscv_pkg.sv | 114 +++++++++++
 rtl/multicycle_control_unit_alu_decoder.sv | 44 ++++
 rtl/multicycle_control_unit.sv | 277 +++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// opcodes, ALU operations, immediate formats, FSM states and mux selects.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    // FETCH must stay at zero so the state output reads 0 during reset
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        ALU_CLASS_ADD = 2'd0,
        ALU_CLASS_R   = 2'd1,
        ALU_CLASS_I   = 2'd2
    } alu_class_e;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_e    alu_ctrl;
        imm_src_e   imm_src;
        logic [1:0] result_src;
        logic [2:0] mem_read;
        logic       instr_done;
    } ctrl_t;

    function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                          input logic lt, input logic ltu);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic load_funct3_ok(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
    endfunction

    function automatic logic store_funct3_ok(input logic [2:0] funct3);
        return funct3 <= 3'b010;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU operation decode from the instruction class, funct3 and funct7[5].
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_class_e  alu_class_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_5_i,
    output alu_op_e     alu_ctrl_o
);

    // funct7[5] selects SUB only for register ops, and SRA for both classes
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_class_i)
            ALU_CLASS_R, ALU_CLASS_I: begin
                case (funct3_i)
                    3'b000: begin
                        if ((alu_class_i == ALU_CLASS_R) && funct7_5_i) begin
                            alu_ctrl_o = ALU_SUB;
                        end else begin
                            alu_ctrl_o = ALU_ADD;
                        end
                    end
                    3'b001: alu_ctrl_o = ALU_SLL;
                    3'b010: alu_ctrl_o = ALU_SLT;
                    3'b011: alu_ctrl_o = ALU_SLTU;
                    3'b100: alu_ctrl_o = ALU_XOR;
                    3'b101: begin
                        if (funct7_5_i) begin
                            alu_ctrl_o = ALU_SRA;
                        end else begin
                            alu_ctrl_o = ALU_SRL;
                        end
                    end
                    3'b110: alu_ctrl_o = ALU_OR;
                    3'b111: alu_ctrl_o = ALU_AND;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single req/ready memory port.
module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_LANES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic                  eq_i,
    input  logic                  lt_i,
    input  logic                  ltu_i,
    input  logic                  mem_ready_i,
    output logic                  mem_req_o,
    output logic                  adr_src_o,
    output logic                  ir_write_o,
    output logic                  pc_write_o,
    output logic                  reg_write_o,
    output logic [1:0]            alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic [3:0]            alu_ctrl_o,
    output logic [2:0]            imm_src_o,
    output logic [1:0]            result_src_o,
    output logic [BYTE_LANES-1:0] mem_write_o,
    output logic [2:0]            mem_read_o,
    output logic                  instr_done_o,
    output logic                  illegal_o,
    output logic [3:0]            state_o
);

    state_e                state_q, state_d;
    logic                  illegal_q, illegal_d;
    ctrl_t                 ctrl_s, ctrl_out_s;
    logic [BYTE_LANES-1:0] store_be_s, mem_write_s;
    alu_class_e            alu_class_s;
    alu_op_e               alu_dec_s;

    logic [31:0] ir_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        funct7_5_s;
    logic        unused_ir_s;

    assign ir_s        = instr_i[31:0];
    assign opcode_s    = ir_s[6:0];
    assign funct3_s    = ir_s[14:12];
    assign funct7_5_s  = ir_s[30];
    assign unused_ir_s = ^{ir_s[31], ir_s[29:15], ir_s[11:7]};

    alu_decoder u_alu_decoder (
        .alu_class_i (alu_class_s),
        .funct3_i    (funct3_s),
        .funct7_5_i  (funct7_5_s),
        .alu_ctrl_o  (alu_dec_s)
    );

    // Instruction class seen by the ALU decoder (LUI/AUIPC always add)
    always_comb begin
        alu_class_s = ALU_CLASS_ADD;
        if (state_q == S_EXEC_R) begin
            alu_class_s = ALU_CLASS_R;
        end else if ((state_q == S_EXEC_I) && (opcode_s == OP_IMM)) begin
            alu_class_s = ALU_CLASS_I;
        end else begin
            alu_class_s = ALU_CLASS_ADD;
        end
    end

    // Store byte enables by access size
    always_comb begin
        store_be_s = '0;
        case (funct3_s)
            3'b000:  store_be_s = BYTE_LANES'(2'b01);
            3'b001:  store_be_s = BYTE_LANES'(2'b11);
            3'b010:  store_be_s = {BYTE_LANES{1'b1}};
            default: store_be_s = '0;
        endcase
    end

    // Next-state and control decode
    always_comb begin
        state_d              = state_q;
        ctrl_s               = '0;
        ctrl_s.alu_src_a     = SRCA_PC;
        ctrl_s.alu_src_b     = SRCB_RS2;
        ctrl_s.alu_ctrl      = ALU_ADD;
        ctrl_s.imm_src       = IMM_I;
        ctrl_s.result_src    = RES_ALUOUT;
        mem_write_s          = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.mem_req    = 1'b1;
                ctrl_s.alu_src_b  = SRCB_FOUR;
                ctrl_s.result_src = RES_ALU;
                if (mem_ready_i) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                    state_d         = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Speculatively form OldPC+imm so branch/JAL targets sit in ALUOut
                ctrl_s.alu_src_a = SRCA_OLDPC;
                ctrl_s.alu_src_b = SRCB_IMM;
                case (opcode_s)
                    OP_STORE:         ctrl_s.imm_src = IMM_S;
                    OP_BRANCH:        ctrl_s.imm_src = IMM_B;
                    OP_LUI, OP_AUIPC: ctrl_s.imm_src = IMM_U;
                    OP_JAL:           ctrl_s.imm_src = IMM_J;
                    default:          ctrl_s.imm_src = IMM_I;
                endcase
                case (opcode_s)
                    OP_LOAD, OP_STORE:        state_d = S_MEMADR;
                    OP_R:                     state_d = S_EXEC_R;
                    OP_IMM, OP_LUI, OP_AUIPC: state_d = S_EXEC_I;
                    OP_BRANCH:                state_d = S_BRANCH;
                    OP_JAL:                   state_d = S_JAL;
                    OP_JALR: begin
                        if (funct3_s == 3'b000) begin
                            state_d = S_JALR;
                        end else begin
                            state_d = S_HALT;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ctrl_s.alu_src_a = SRCA_RS1;
                ctrl_s.alu_src_b = SRCB_IMM;
                if (opcode_s == OP_LOAD) begin
                    ctrl_s.imm_src = IMM_I;
                    state_d = load_funct3_ok(funct3_s) ? S_MEMREAD : S_HALT;
                end else begin
                    ctrl_s.imm_src = IMM_S;
                    state_d = store_funct3_ok(funct3_s) ? S_MEMWRITE : S_HALT;
                end
            end
            S_MEMREAD: begin
                ctrl_s.mem_req  = 1'b1;
                ctrl_s.adr_src  = 1'b1;
                ctrl_s.mem_read = funct3_s;
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                ctrl_s.result_src = RES_MEMDATA;
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.adr_src = 1'b1;
                mem_write_s    = store_be_s;
                if (mem_ready_i) begin
                    ctrl_s.instr_done = 1'b1;
                    state_d           = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXEC_R: begin
                ctrl_s.alu_src_a = SRCA_RS1;
                ctrl_s.alu_src_b = SRCB_RS2;
                ctrl_s.alu_ctrl  = alu_dec_s;
                state_d          = S_ALUWB;
            end
            S_EXEC_I: begin
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_ctrl  = alu_dec_s;
                if (opcode_s == OP_LUI) begin
                    ctrl_s.alu_src_a = SRCA_ZERO;
                    ctrl_s.imm_src   = IMM_U;
                end else if (opcode_s == OP_AUIPC) begin
                    ctrl_s.alu_src_a = SRCA_OLDPC;
                    ctrl_s.imm_src   = IMM_U;
                end else begin
                    ctrl_s.alu_src_a = SRCA_RS1;
                    ctrl_s.imm_src   = IMM_I;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
                // JALR's PC write consumed the ALU, so the link value is built here
                if (opcode_s == OP_JALR) begin
                    ctrl_s.alu_src_a  = SRCA_OLDPC;
                    ctrl_s.alu_src_b  = SRCB_FOUR;
                    ctrl_s.result_src = RES_ALU;
                end else begin
                    ctrl_s.result_src = RES_ALUOUT;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a  = SRCA_RS1;
                ctrl_s.alu_src_b  = SRCB_RS2;
                ctrl_s.alu_ctrl   = ALU_SUB;
                ctrl_s.result_src = RES_ALUOUT;
                if ((funct3_s == 3'b010) || (funct3_s == 3'b011)) begin
                    state_d = S_HALT;
                end else begin
                    ctrl_s.pc_write   = branch_taken(funct3_s, eq_i, lt_i, ltu_i);
                    ctrl_s.instr_done = 1'b1;
                    state_d           = S_FETCH;
                end
            end
            S_JAL: begin
                ctrl_s.alu_src_a  = SRCA_OLDPC;
                ctrl_s.alu_src_b  = SRCB_FOUR;
                ctrl_s.imm_src    = IMM_J;
                ctrl_s.result_src = RES_ALUOUT;
                ctrl_s.pc_write   = 1'b1;
                state_d           = S_ALUWB;
            end
            S_JALR: begin
                ctrl_s.alu_src_a  = SRCA_RS1;
                ctrl_s.alu_src_b  = SRCB_IMM;
                ctrl_s.imm_src    = IMM_I;
                ctrl_s.result_src = RES_ALU;
                ctrl_s.pc_write   = 1'b1;
                state_d           = S_ALUWB;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Reset forces every control output low, even though the state reads FETCH
    always_comb begin
        if (rst) begin
            ctrl_out_s  = '0;
            mem_write_o = '0;
        end else begin
            ctrl_out_s  = ctrl_s;
            mem_write_o = mem_write_s;
        end
    end

    assign illegal_d = illegal_q | (state_d == S_HALT);

    // State and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_req_o    = ctrl_out_s.mem_req;
    assign adr_src_o    = ctrl_out_s.adr_src;
    assign ir_write_o   = ctrl_out_s.ir_write;
    assign pc_write_o   = ctrl_out_s.pc_write;
    assign reg_write_o  = ctrl_out_s.reg_write;
    assign alu_src_a_o  = ctrl_out_s.alu_src_a;
    assign alu_src_b_o  = ctrl_out_s.alu_src_b;
    assign alu_ctrl_o   = ctrl_out_s.alu_ctrl;
    assign imm_src_o    = ctrl_out_s.imm_src;
    assign result_src_o = ctrl_out_s.result_src;
    assign mem_read_o   = ctrl_out_s.mem_read;
    assign instr_done_o = ctrl_out_s.instr_done;
    assign illegal_o    = illegal_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: a per-instruction cycle model queues expected outputs,
// a negedge monitor pops and compares them against the control unit.
module tb_multicycle_control_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_i = 32'd0;
    logic        eq_i = 1'b0, lt_i = 1'b0, ltu_i = 1'b0, mem_ready_i = 1'b0;
    logic        mem_req_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0]  alu_src_a_o, alu_src_b_o, result_src_o;
    logic [3:0]  alu_ctrl_o, mem_write_o, state_o;
    logic [2:0]  imm_src_o, mem_read_o;
    logic        instr_done_o, illegal_o;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .instr_i(instr_i), .eq_i(eq_i), .lt_i(lt_i), .ltu_i(ltu_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .adr_src_o(adr_src_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_ctrl_o(alu_ctrl_o),
        .imm_src_o(imm_src_o), .result_src_o(result_src_o), .mem_write_o(mem_write_o),
        .mem_read_o(mem_read_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       rdy, req, adr, irw, pcw, rw, done, ill;
        logic [3:0] mw, alu;
        logic [2:0] mr, imm;
        logic [1:0] sa, sb, rs;
        logic       ck_mux, ck_rs, ck_imm, ck_adr, ck_mr;
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_r;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [3:0] st);
        rec_t r;
        r.st = st; r.rdy = 1'($urandom & 32'd1);
        r.req = 1'b0; r.adr = 1'b0; r.irw = 1'b0; r.pcw = 1'b0; r.rw = 1'b0;
        r.done = 1'b0; r.ill = 1'b0; r.mw = 4'd0; r.alu = 4'd0; r.mr = 3'd0;
        r.imm = 3'd0; r.sa = 2'd0; r.sb = 2'd0; r.rs = 2'd0;
        r.ck_mux = 1'b0; r.ck_rs = 1'b0; r.ck_imm = 1'b0; r.ck_adr = 1'b0; r.ck_mr = 1'b0;
        return r;
    endfunction

    function automatic rec_t mux(input rec_t ri, input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [3:0] alu);
        rec_t r;
        r = ri; r.sa = sa; r.sb = sb; r.alu = alu; r.ck_mux = 1'b1;
        return r;
    endfunction

    // ALU operation implied by the RV32I mnemonic
    function automatic logic [3:0] exp_alu(input bit r_type, input logic [2:0] f3, input logic f7b5);
        case (f3)
            3'd0: return (r_type && f7b5) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return f7b5 ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0100011: return IMM_S;
            7'b1100011: return IMM_B;
            7'b0110111, 7'b0010111: return IMM_U;
            7'b1101111: return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                          7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};
    endfunction

    // Monitor: compare every cycle for which the model queued an expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_r = exp_q.pop_front();
            check("state", 32'(state_o), 32'(mon_r.st));
            check("mem_req", 32'(mem_req_o), 32'(mon_r.req));
            check("ir_write", 32'(ir_write_o), 32'(mon_r.irw));
            check("pc_write", 32'(pc_write_o), 32'(mon_r.pcw));
            check("reg_write", 32'(reg_write_o), 32'(mon_r.rw));
            check("instr_done", 32'(instr_done_o), 32'(mon_r.done));
            check("mem_write", 32'(mem_write_o), 32'(mon_r.mw));
            check("illegal", 32'(illegal_o), 32'(mon_r.ill));
            if (mon_r.ck_adr) check("adr_src", 32'(adr_src_o), 32'(mon_r.adr));
            if (mon_r.ck_mux) begin
                check("alu_src_a", 32'(alu_src_a_o), 32'(mon_r.sa));
                check("alu_src_b", 32'(alu_src_b_o), 32'(mon_r.sb));
                check("alu_ctrl", 32'(alu_ctrl_o), 32'(mon_r.alu));
            end
            if (mon_r.ck_rs) check("result_src", 32'(result_src_o), 32'(mon_r.rs));
            if (mon_r.ck_imm) check("imm_src", 32'(imm_src_o), 32'(mon_r.imm));
            if (mon_r.ck_mr) check("mem_read", 32'(mem_read_o), 32'(mon_r.mr));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_mem_write"}, 32'(mem_write_o), 32'd0);
        check({tag, "_ctrl"}, 32'({adr_src_o, ir_write_o, pc_write_o, reg_write_o, instr_done_o}), 32'd0);
        check({tag, "_mux"}, 32'({alu_src_a_o, alu_src_b_o, alu_ctrl_o, imm_src_o, result_src_o, mem_read_o}), 32'd0);
        check({tag, "_illegal"}, 32'(illegal_o), 32'd0);
        check({tag, "_state"}, 32'(state_o), 32'(S_FETCH));
    endtask

    // Asynchronous reset from the current point; returns just after an edge with rst low
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst = 1'b0;
    endtask

    // Build the cycle-by-cycle expectation of one instruction, then drive it
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mwait,
                             input logic [2:0] flg, input int hold, input int keep,
                             output bit halted);
        rec_t       recs[$];
        rec_t       r;
        logic [6:0] op;
        logic [2:0] f3;
        logic [3:0] be;
        op = ins[6:0];
        f3 = ins[14:12];
        halted = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            r = mux(mk(S_FETCH), 2'b00, 2'b10, ALU_ADD);
            r.req = 1'b1; r.ck_adr = 1'b1; r.rs = 2'b10; r.ck_rs = 1'b1;
            r.rdy = (i == fw);
            r.irw = (i == fw); r.pcw = (i == fw);
            recs.push_back(r);
        end
        r = mux(mk(S_DECODE), 2'b01, 2'b01, ALU_ADD);
        r.imm = exp_imm(op); r.ck_imm = known_op(op);
        recs.push_back(r);
        case (op)
            7'b0000011, 7'b0100011: begin
                r = mux(mk(S_MEMADR), 2'b10, 2'b01, ALU_ADD);
                r.imm = exp_imm(op); r.ck_imm = 1'b1;
                recs.push_back(r);
                be = (f3 == 3'd0) ? 4'b0001 : (f3 == 3'd1) ? 4'b0011 : 4'b1111;
                if (op == 7'b0000011 && f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                    for (int i = 0; i <= mwait; i++) begin
                        r = mk(S_MEMREAD);
                        r.req = 1'b1; r.adr = 1'b1; r.ck_adr = 1'b1; r.mr = f3; r.ck_mr = 1'b1;
                        r.rdy = (i == mwait);
                        recs.push_back(r);
                    end
                    r = mk(S_MEMWB); r.rw = 1'b1; r.done = 1'b1; r.rs = 2'b01; r.ck_rs = 1'b1;
                    recs.push_back(r);
                end else if (op == 7'b0100011 && f3 <= 3'd2) begin
                    for (int i = 0; i <= mwait; i++) begin
                        r = mk(S_MEMWRITE);
                        r.req = 1'b1; r.adr = 1'b1; r.ck_adr = 1'b1; r.mw = be;
                        r.rdy = (i == mwait); r.done = (i == mwait);
                        recs.push_back(r);
                    end
                end else begin
                    halted = 1'b1;
                end
            end
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                if (op == 7'b0110011) begin
                    r = mux(mk(S_EXEC_R), 2'b10, 2'b00, exp_alu(1'b1, f3, ins[30]));
                end else begin
                    r = mux(mk(S_EXEC_I), (op == 7'b0110111) ? 2'b11 : (op == 7'b0010111) ? 2'b01 : 2'b10,
                            2'b01, (op == 7'b0010011) ? exp_alu(1'b0, f3, ins[30]) : ALU_ADD);
                    r.imm = exp_imm(op); r.ck_imm = 1'b1;
                end
                recs.push_back(r);
                r = mk(S_ALUWB); r.rw = 1'b1; r.done = 1'b1; r.ck_rs = 1'b1; r.rs = 2'b00;
                recs.push_back(r);
            end
            7'b1100011: begin
                r = mux(mk(S_BRANCH), 2'b10, 2'b00, ALU_SUB);
                r.ck_rs = 1'b1; r.rs = 2'b00;
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    halted = 1'b1;
                end else begin
                    r.done = 1'b1;
                    case (f3)
                        3'd0: r.pcw = flg[2];
                        3'd1: r.pcw = !flg[2];
                        3'd4: r.pcw = flg[1];
                        3'd5: r.pcw = !flg[1];
                        3'd6: r.pcw = flg[0];
                        default: r.pcw = !flg[0];
                    endcase
                end
                recs.push_back(r);
            end
            7'b1101111: begin
                r = mux(mk(S_JAL), 2'b01, 2'b10, ALU_ADD);
                r.pcw = 1'b1; r.ck_rs = 1'b1; r.rs = 2'b00;
                recs.push_back(r);
                r = mk(S_ALUWB); r.rw = 1'b1; r.done = 1'b1; r.ck_rs = 1'b1; r.rs = 2'b00;
                recs.push_back(r);
            end
            7'b1100111: begin
                if (f3 == 3'd0) begin
                    r = mux(mk(S_JALR), 2'b10, 2'b01, ALU_ADD);
                    r.pcw = 1'b1; r.ck_rs = 1'b1; r.rs = 2'b10; r.imm = IMM_I; r.ck_imm = 1'b1;
                    recs.push_back(r);
                    r = mux(mk(S_ALUWB), 2'b01, 2'b10, ALU_ADD);
                    r.rw = 1'b1; r.done = 1'b1; r.ck_rs = 1'b1; r.rs = 2'b10;
                    recs.push_back(r);
                end else begin
                    halted = 1'b1;
                end
            end
            default: halted = 1'b1;
        endcase
        if (halted) begin
            for (int i = 0; i < hold; i++) begin
                r = mk(S_HALT); r.ill = 1'b1;
                recs.push_back(r);
            end
        end
        while (keep > 0 && recs.size() > keep) recs.delete(recs.size() - 1);
        instr_i = ins;
        {eq_i, lt_i, ltu_i} = flg;
        foreach (recs[i]) exp_q.push_back(recs[i]);
        foreach (recs[i]) begin
            mem_ready_i = recs[i].rdy;
            @(posedge clk);
            #1;
        end
    endtask

    logic [6:0]  ops [0:8];
    logic [31:0] rins;
    bit          h;

    initial begin
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111};
        #2;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;
        do_reset();

        run_instr(32'h002081B3, 0, 0, 3'b000, 0, 0, h);  // add
        run_instr(32'h0000A283, 0, 3, 3'b000, 0, 0, h);  // lw, 3 wait cycles
        run_instr(32'h00208023, 1, 2, 3'b000, 0, 0, h);  // sb
        run_instr(32'h00209023, 0, 1, 3'b000, 0, 0, h);  // sh
        run_instr(32'h0020A023, 0, 0, 3'b000, 0, 0, h);  // sw
        run_instr(32'h0020D063, 0, 0, 3'b000, 0, 0, h);  // bge, LT=0
        run_instr(32'h0020D063, 0, 0, 3'b010, 0, 0, h);  // bge, LT=1
        run_instr(32'h0020E063, 0, 0, 3'b001, 0, 0, h);  // bltu, LTU=1
        run_instr(32'h0000006F, 0, 0, 3'b000, 0, 0, h);  // jal
        run_instr(32'h00008067, 2, 0, 3'b000, 0, 0, h);  // jalr
        run_instr(32'h000012B7, 0, 0, 3'b000, 0, 0, h);  // lui
        run_instr(32'h00001297, 0, 0, 3'b000, 0, 0, h);  // auipc
        run_instr(32'h4010D093, 0, 0, 3'b000, 0, 0, h);  // srai
        run_instr(32'h402081B3, 0, 0, 3'b000, 0, 0, h);  // sub
        run_instr(32'h4000C0B3, 0, 0, 3'b000, 0, 0, h);  // xor with funct7[5] set
        run_instr(32'h0020A063, 0, 0, 3'b000, 4, 0, h);  // branch funct3=010
        do_reset();
        run_instr(32'h00000000, 0, 0, 3'b000, 20, 0, h); // opcode 0 -> halt
        do_reset();
        run_instr(32'h0000B283, 0, 0, 3'b000, 3, 0, h);  // reserved load funct3
        do_reset();

        // Abort a store while it waits on memory
        run_instr(32'h00208023, 0, 5, 3'b000, 0, 3, h);
        mem_ready_i = 1'b0;
        #1;
        check("midwr_state", 32'(state_o), 32'(S_MEMWRITE));
        check("midwr_mem_req", 32'(mem_req_o), 32'd1);
        check("midwr_mem_write", 32'(mem_write_o), 32'b0001);
        do_reset();
        run_instr(32'h002081B3, 0, 0, 3'b000, 0, 0, h);

        for (int n = 0; n < 150; n++) begin
            rins = $urandom;
            rins[6:0] = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 15) == 0) rins[6:0] = 7'($urandom);
            run_instr(rins, $urandom_range(0, 2), $urandom_range(0, 3), 3'($urandom),
                      $urandom_range(1, 3), 0, h);
            if (h) do_reset();
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
